// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: matches a received command byte against a table of handler
// codes, keeps the selected handler's activate high until it reports done or
// times out, and routes that handler's transmit request to the shared UART
// transmitter. Unknown commands and timeouts answer with a NAK byte.
module cmd_dispatcher #(
    parameter int         N_HANDLERS     = 5,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         CNT_W          = 26
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_rx_ready,
    input  logic [7:0]                i_rx_data,
    input  logic [8*N_HANDLERS-1:0]   i_cmd_codes,
    output logic [N_HANDLERS-1:0]     o_activate,
    input  logic [N_HANDLERS-1:0]     i_done,
    input  logic [8*N_HANDLERS-1:0]   i_hnd_tx_data,
    input  logic [N_HANDLERS-1:0]     i_hnd_tx_start,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_start,
    input  logic                      i_tx_active,
    input  logic                      i_tx_done,
    output logic [7:0]                o_state_code,
    output logic                      o_busy,
    output logic [7:0]                o_err_cnt
);

    localparam int SEL_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_NAK_SEND = 3'd2;
    localparam logic [2:0] S_NAK_WAIT = 3'd3;
    localparam logic [2:0] S_GUARD    = 3'd4;

    logic [2:0]            r_state;
    logic [SEL_W-1:0]      r_sel;
    logic [7:0]            r_state_code;
    logic [7:0]            r_err_cnt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_first;     // high during the first RUN cycle

    logic [N_HANDLERS-1:0] w_hit;
    logic                  w_hit_any;
    logic [SEL_W-1:0]      w_hit_idx;
    logic [7:0]            w_sel_tx_data;
    logic                  w_sel_tx_start;
    logic                  w_sel_done;
    logic                  w_done_q;
    logic                  w_timeout;
    logic [7:0]            w_err_inc;

    // Per-handler match; a zero table entry marks an unused slot.
    genvar gi;
    generate
        for (gi = 0; gi < N_HANDLERS; gi++) begin : g_match
            assign w_hit[gi] = (i_rx_data == i_cmd_codes[gi*8 +: 8]) &&
                               (i_cmd_codes[gi*8 +: 8] != 8'h00);
            assign o_activate[gi] = (r_state == S_RUN) && (r_sel == SEL_W'(gi));
        end
    endgenerate

    assign w_hit_any = |w_hit;

    // Lowest matching index wins: scan downward so the lowest hit is last.
    always_comb begin
        w_hit_idx = '0;
        for (int i = N_HANDLERS - 1; i >= 0; i--) begin
            if (w_hit[i]) w_hit_idx = SEL_W'(i);
        end
    end

    // Select the running handler's transmit request and done level.
    always_comb begin
        w_sel_tx_data  = 8'h00;
        w_sel_tx_start = 1'b0;
        w_sel_done     = 1'b0;
        for (int i = 0; i < N_HANDLERS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_tx_data  = i_hnd_tx_data[i*8 +: 8];
                w_sel_tx_start = i_hnd_tx_start[i];
                w_sel_done     = i_done[i];
            end
        end
    end

    // A done level left over from the previous run is ignored on the first cycle.
    assign w_done_q  = w_sel_done && !r_first;
    assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Dispatcher state machine, error counter and timeout counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_state_code <= 8'h00;
            r_err_cnt    <= 8'h00;
            r_cnt        <= '0;
            r_first      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_ready) begin
                        if (w_hit_any) begin
                            r_state      <= S_RUN;
                            r_sel        <= w_hit_idx;
                            r_state_code <= i_rx_data;
                            r_cnt        <= '0;
                            r_first      <= 1'b1;
                        end else begin
                            r_state   <= S_NAK_SEND;
                            r_err_cnt <= w_err_inc;
                        end
                    end
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    if (w_done_q) begin
                        r_state      <= S_IDLE;
                        r_state_code <= 8'h00;
                    end else if (w_timeout) begin
                        r_state   <= S_GUARD;
                        r_err_cnt <= w_err_inc;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (!i_tx_active) r_state <= S_NAK_SEND;
                end
                S_NAK_SEND: begin
                    if (!i_tx_active) r_state <= S_NAK_WAIT;
                end
                S_NAK_WAIT: begin
                    if (i_tx_done) begin
                        r_state      <= S_IDLE;
                        r_state_code <= 8'h00;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Transmitter mux: handler passthrough in RUN, NAK byte in the NAK states.
    always_comb begin
        o_tx_data  = 8'h00;
        o_tx_start = 1'b0;
        case (r_state)
            S_RUN: begin
                o_tx_data  = w_sel_tx_data;
                o_tx_start = w_sel_tx_start;
            end
            S_NAK_SEND: begin
                o_tx_data  = NAK_BYTE;
                o_tx_start = !i_tx_active;
            end
            S_NAK_WAIT: begin
                o_tx_data  = NAK_BYTE;
            end
            default: begin
                o_tx_data  = 8'h00;
                o_tx_start = 1'b0;
            end
        endcase
    end

    assign o_state_code = r_state_code;
    assign o_busy       = (r_state != S_IDLE);
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed testbench for cmd_dispatcher: five handlers, 100-cycle timeout.
module tb_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [39:0] cmd_codes;
    logic [4:0]  activate;
    logic [4:0]  done;
    logic [39:0] hnd_tx_data;
    logic [4:0]  hnd_tx_start;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_active;
    logic        tx_done;
    logic [7:0]  state_code;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_dispatcher #(
        .N_HANDLERS(5), .TIMEOUT_CYCLES(100), .NAK_BYTE(8'h15), .CNT_W(8)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_rx_ready(rx_ready), .i_rx_data(rx_data),
        .i_cmd_codes(cmd_codes), .o_activate(activate), .i_done(done),
        .i_hnd_tx_data(hnd_tx_data), .i_hnd_tx_start(hnd_tx_start),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_active(tx_active),
        .i_tx_done(tx_done), .o_state_code(state_code), .o_busy(busy),
        .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command byte for a single sampling edge.
    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++; if (activate !== 5'b0) begin n_fail++; $display("FAIL reset_activate: got %b expected 00000", activate); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (state_code !== 8'h00) begin n_fail++; $display("FAIL reset_state_code: got %h expected 00", state_code); end
        n_tests++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); end
        n_tests++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx: got start=%b data=%h expected 0/00", tx_start, tx_data); end
        #1 rst_n = 1'b1;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_normal_run();
        send_cmd(8'h71);
        n_tests++; if (activate !== 5'b01000) begin n_fail++; $display("FAIL run_activate: got %b expected 01000", activate); end
        n_tests++; if (state_code !== 8'h71) begin n_fail++; $display("FAIL run_state_code: got %h expected 71", state_code); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %b expected 1", busy); end
        // done from a non-selected handler must not end the run
        done = 5'b00001;
        tick();
        done = 5'b00000;
        n_tests++; if (activate !== 5'b01000) begin n_fail++; $display("FAIL run_other_done: got %b expected 01000", activate); end
        for (int k = 0; k < 8; k++) tick();
        // done[3] plus a coinciding rx_ready which must be dropped
        done     = 5'b01000;
        rx_data  = 8'h11;
        rx_ready = 1'b1;
        tick();
        done     = 5'b00000;
        rx_ready = 1'b0;
        n_tests++; if (activate !== 5'b00000) begin n_fail++; $display("FAIL done_activate: got %b expected 00000", activate); end
        n_tests++; if (state_code !== 8'h00) begin n_fail++; $display("FAIL done_state_code: got %h expected 00", state_code); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b expected 0", busy); end
        tick();
        n_tests++; if (busy !== 1'b0 || activate !== 5'b0) begin n_fail++; $display("FAIL rx_dropped: got busy=%b act=%b expected 0/00000", busy, activate); end
        $display("[TB] normal run 8'h71 on handler 3");
    endtask

    task automatic test_unknown();
        logic [7:0] cmds [2];
        cmds[0] = 8'h55;
        cmds[1] = 8'h00;
        for (int c = 0; c < 2; c++) begin
            send_cmd(cmds[c]);
            n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'h15) begin n_fail++; $display("FAIL nak_pulse[%0d]: got start=%b data=%h expected 1/15", c, tx_start, tx_data); end
            n_tests++; if (activate !== 5'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nak_state[%0d]: got act=%b busy=%b expected 00000/1", c, activate, busy); end
            tick();
            n_tests++; if (tx_start !== 1'b0 || tx_data !== 8'h15) begin n_fail++; $display("FAIL nak_wait[%0d]: got start=%b data=%h expected 0/15", c, tx_start, tx_data); end
            send_cmd(8'h11);  // ignored while waiting for tx_done
            n_tests++; if (activate !== 5'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL nak_rx_ignored[%0d]: got act=%b start=%b expected 00000/0", c, activate, tx_start); end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            n_tests++; if (busy !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL nak_end[%0d]: got busy=%b data=%h expected 0/00", c, busy, tx_data); end
            $display("[TB] unknown command %h answered with NAK", cmds[c]);
        end
        n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL unknown_err_cnt: got %0d expected 2", err_cnt); end
    endtask

    task automatic test_timeout();
        int high_cycles;
        tx_active = 1'b1;
        send_cmd(8'h11);
        high_cycles = 0;
        while (activate[0] === 1'b1 && high_cycles < 200) begin
            high_cycles++;
            tick();
        end
        n_tests++; if (high_cycles !== 100) begin n_fail++; $display("FAIL timeout_len: got %0d expected 100", high_cycles); end
        n_tests++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d expected 3", err_cnt); end
        n_tests++; if (busy !== 1'b1 || state_code !== 8'h11) begin n_fail++; $display("FAIL guard_state: got busy=%b code=%h expected 1/11", busy, state_code); end
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL guard_no_start[%0d]: got %b expected 0", k, tx_start); end
            tick();
        end
        tx_active = 1'b0;
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL guard_exit: got %b expected 0", tx_start); end
        tick();
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'h15) begin n_fail++; $display("FAIL timeout_nak: got start=%b data=%h expected 1/15", tx_start, tx_data); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_tests++; if (busy !== 1'b0 || state_code !== 8'h00) begin n_fail++; $display("FAIL timeout_end: got busy=%b code=%h expected 0/00", busy, state_code); end
        $display("[TB] timeout after %0d cycles on handler 0", high_cycles);
    endtask

    task automatic test_stale_done();
        done = 5'b00010;
        send_cmd(8'h21);
        n_tests++; if (activate !== 5'b00010) begin n_fail++; $display("FAIL stale_enter: got %b expected 00010", activate); end
        tick();
        n_tests++; if (activate !== 5'b00010) begin n_fail++; $display("FAIL stale_first_cycle: got %b expected 00010", activate); end
        tick();
        done = 5'b00000;
        n_tests++; if (activate !== 5'b00000 || busy !== 1'b0) begin n_fail++; $display("FAIL stale_second_cycle: got act=%b busy=%b expected 00000/0", activate, busy); end
        $display("[TB] stale done ignored on first RUN cycle");
    endtask

    task automatic test_done_vs_timeout();
        send_cmd(8'h22);
        for (int k = 0; k < 99; k++) tick();
        n_tests++; if (activate !== 5'b00100) begin n_fail++; $display("FAIL race_last_cycle: got %b expected 00100", activate); end
        done = 5'b00100;
        tick();
        done = 5'b00000;
        n_tests++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL race_exit: got busy=%b start=%b expected 0/0", busy, tx_start); end
        n_tests++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL race_err_cnt: got %0d expected 3", err_cnt); end
        $display("[TB] done wins over coinciding timeout");
    endtask

    task automatic test_tx_mux();
        hnd_tx_start = 5'b00001;
        hnd_tx_data  = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h5A};
        #1;
        n_tests++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mux_idle: got start=%b data=%h expected 0/00", tx_start, tx_data); end
        hnd_tx_start = 5'b00000;
        send_cmd(8'h72);
        n_tests++; if (activate !== 5'b10000) begin n_fail++; $display("FAIL mux_select: got %b expected 10000", activate); end
        hnd_tx_start = 5'b10001;
        #1;
        n_tests++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL mux_forward: got start=%b data=%h expected 1/a5", tx_start, tx_data); end
        hnd_tx_start = 5'b00001;
        #1;
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL mux_block_other: got %b expected 0", tx_start); end
        hnd_tx_start = 5'b00000;
        tick();
        done = 5'b10000;
        tick();
        done = 5'b00000;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mux_exit: got %b expected 0", busy); end
        $display("[TB] tx mux forwards handler 4 only");
    endtask

    task automatic test_reset_mid_run();
        send_cmd(8'h11);
        n_tests++; if (activate !== 5'b00001) begin n_fail++; $display("FAIL mid_enter: got %b expected 00001", activate); end
        #3 rst_n = 1'b0;
        #1;
        n_tests++; if (activate !== 5'b0 || state_code !== 8'h00) begin n_fail++; $display("FAIL mid_reset: got act=%b code=%h expected 00000/00", activate, state_code); end
        n_tests++; if (busy !== 1'b0 || err_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_reset_regs: got busy=%b err=%0d expected 0/0", busy, err_cnt); end
        #2 rst_n = 1'b1;
        tick();
        $display("[TB] asynchronous reset mid-run");
    endtask

    task automatic test_saturation();
        int exp_err;
        for (int k = 1; k <= 300; k++) begin
            send_cmd(8'h55);
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (k == 254 || k == 255 || k == 256 || k == 300) begin
                exp_err = (k > 255) ? 255 : k;
                n_tests++; if (err_cnt !== exp_err[7:0]) begin n_fail++; $display("FAIL sat_err_cnt[%0d]: got %0d expected %0d", k, err_cnt, exp_err); end
            end
        end
        $display("[TB] 300 unknown commands, err_cnt=%0d", err_cnt);
    endtask

    initial begin
        rx_ready     = 1'b0;
        rx_data      = 8'h00;
        cmd_codes    = {8'h72, 8'h71, 8'h22, 8'h21, 8'h11};
        done         = 5'b0;
        hnd_tx_data  = '0;
        hnd_tx_start = 5'b0;
        tx_active    = 1'b0;
        tx_done      = 1'b0;
        test_reset();
        test_normal_run();
        test_unknown();
        test_timeout();
        test_stale_done();
        test_done_vs_timeout();
        test_tx_mux();
        test_reset_mid_run();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
